// File: rtl/arith_pipe_pkg.sv
// Shared definitions for the arithmetic pipeline: op_mode encodings and width helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arith_pipe_pkg;

  // Operation select, sampled alongside the operands.
  typedef enum logic [1:0] {
    OP_APB_CMD = 2'b00,  // (a+b)*(c-d)
    OP_AMB_CPD = 2'b01,  // (a-b)*(c+d)
    OP_APB_CPD = 2'b10,  // (a+b)*(c+d)
    OP_AMB_CMD = 2'b11   // (a-b)*(c-d)
  } op_mode_t;

  // Full-precision product width for W-bit operands: two (W+1)-bit terms multiplied.
  function automatic int full_width(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/arith_pipe_reduce.sv
// Reduces a full-precision signed product to OUT_W bits (clamp with ARITH_SAT_EN, else wrap).
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module arith_pipe_reduce
  import arith_pipe_pkg::*;
#(
  parameter int IN_W  = full_width(8),
  parameter int OUT_W = full_width(8)
) (
  input  logic signed [IN_W-1:0]  p,
  output logic signed [OUT_W-1:0] y
`ifdef ARITH_SAT_EN
  ,
  output logic                    sat
`endif
);

  if (OUT_W < IN_W) begin : g_narrow
`ifdef ARITH_SAT_EN
    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
    logic ovf;

    // The value fits only if every bit above the kept sign bit matches the sign.
    assign ovf = (p[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){p[IN_W-1]}});

    // Clamp toward the limit on the side of the true sign.
    always_comb begin
      y   = p[OUT_W-1:0];
      sat = 1'b0;
      if (ovf) begin
        y   = p[IN_W-1] ? MIN_V : MAX_V;
        sat = 1'b1;
      end
    end
`else
    logic unused_hi;
    // Discarded high bits; wrap-around keeps only the low OUT_W bits.
    assign unused_hi = ^p[IN_W-1:OUT_W];
    assign y         = p[OUT_W-1:0];
`endif
  end else begin : g_full
    // Full width: nothing can overflow.
    assign y   = p;
`ifdef ARITH_SAT_EN
    assign sat = 1'b0;
`endif
  end

endmodule

// File: rtl/param_arith_pipe.sv
// Three-stage signed (a+/-b)*(c+/-d) pipeline; optional clamping via macro ARITH_SAT_EN (adds y_sat).
// Latency: result valid 3 cycles after acceptance; one result per cycle when unstalled.
// Backpressure: all stages hold together while out_valid && !out_ready; in_ready drops then.
module param_arith_pipe
  import arith_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int OUT_W = 2 * W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  input  logic signed [W-1:0]     c,
  input  logic signed [W-1:0]     d,
  input  logic [1:0]              op_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y
`ifdef ARITH_SAT_EN
  ,
  output logic                    y_sat
`endif
);

  localparam int FW = full_width(W);

  logic advance;

  // Whole pipe moves as one: free to move whenever the output slot is empty or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !rst_n || advance;

  // ---------------- S1: operand capture ----------------
  logic                s1_vld;
  logic signed [W-1:0] s1_a, s1_b, s1_c, s1_d;
  op_mode_t            s1_mode;

  // Stage-1 valid bit; a bubble enters as an invalid stage.
  always_ff @(posedge clk) begin
    if (!rst_n)       s1_vld <= 1'b0;
    else if (advance) s1_vld <= in_valid;
  end

  // Stage-1 data; frozen while stalled so input changes are ignored.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_a    <= a;
      s1_b    <= b;
      s1_c    <= c;
      s1_d    <= d;
      s1_mode <= op_mode_t'(op_mode);
    end
  end

  // ---------------- S2: add/sub terms ----------------
  logic signed [W:0] ea, eb, ec, ed;
  logic signed [W:0] t1, t2;
  logic              s2_vld;
  logic signed [W:0] s2_t1, s2_t2;

  // One extra bit of headroom makes the sums and differences exact.
  assign ea = {s1_a[W-1], s1_a};
  assign eb = {s1_b[W-1], s1_b};
  assign ec = {s1_c[W-1], s1_c};
  assign ed = {s1_d[W-1], s1_d};

  // Pick the two factors for the selected operation.
  always_comb begin
    t1 = ea + eb;
    t2 = ec - ed;
    case (s1_mode)
      OP_APB_CMD: begin t1 = ea + eb; t2 = ec - ed; end
      OP_AMB_CPD: begin t1 = ea - eb; t2 = ec + ed; end
      OP_APB_CPD: begin t1 = ea + eb; t2 = ec + ed; end
      OP_AMB_CMD: begin t1 = ea - eb; t2 = ec - ed; end
      default:    begin t1 = ea + eb; t2 = ec - ed; end
    endcase
  end

  // Stage-2 valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n)       s2_vld <= 1'b0;
    else if (advance) s2_vld <= s1_vld;
  end

  // Stage-2 factor registers.
  always_ff @(posedge clk) begin
    if (advance) begin
      s2_t1 <= t1;
      s2_t2 <= t2;
    end
  end

  // ---------------- S3: multiply, reduce, output ----------------
  logic signed [FW-1:0]    t1x, t2x, prod;
  logic signed [OUT_W-1:0] y_nxt;
`ifdef ARITH_SAT_EN
  logic                    sat_nxt;
`endif

  assign t1x  = FW'(s2_t1);
  assign t2x  = FW'(s2_t2);
  assign prod = t1x * t2x;

  arith_pipe_reduce #(
    .IN_W  (FW),
    .OUT_W (OUT_W)
  ) u_reduce (
    .p   (prod),
    .y   (y_nxt)
`ifdef ARITH_SAT_EN
    ,
    .sat (sat_nxt)
`endif
  );

  // Output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
`ifdef ARITH_SAT_EN
      y_sat     <= 1'b0;
`endif
    end else if (advance) begin
      out_valid <= s2_vld;
      y         <= y_nxt;
`ifdef ARITH_SAT_EN
      y_sat     <= sat_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_param_arith_pipe.sv
// Directed bench for param_arith_pipe (W=8) with OUT_W=18 and OUT_W=16 instances; honours ARITH_SAT_EN.
// Latency: checks 3-cycle result timing, ordering and one-per-cycle throughput.
// Backpressure: exercises output stalls and mid-flight reset.
module tb_param_arith_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [7:0] a = '0, b = '0, c = '0, d = '0;
  logic [1:0] op_mode = '0;

  logic in_ready18, in_ready16, ov18, ov16;
  logic signed [17:0] y18;
  logic signed [15:0] y16;
`ifdef ARITH_SAT_EN
  logic ysat18, ysat16;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int got_q[$];
  int got_cyc[$];

  always #5 clk = ~clk;

  param_arith_pipe #(.W(8), .OUT_W(18)) u18 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready18),
    .a(a), .b(b), .c(c), .d(d), .op_mode(op_mode),
    .out_valid(ov18), .out_ready(out_ready), .y(y18)
`ifdef ARITH_SAT_EN
    , .y_sat(ysat18)
`endif
  );

  param_arith_pipe #(.W(8), .OUT_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .c(c), .d(d), .op_mode(op_mode),
    .out_valid(ov16), .out_ready(out_ready), .y(y16)
`ifdef ARITH_SAT_EN
    , .y_sat(ysat16)
`endif
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then sample settled outputs.
  task automatic step(input int v, input int ia, input int ib, input int ic, input int id,
                      input int m, input int ordy, output logic acc);
    @(negedge clk);
    in_valid  = v[0];
    a         = 8'(ia);
    b         = 8'(ib);
    c         = 8'(ic);
    d         = 8'(id);
    op_mode   = 2'(m);
    out_ready = ordy[0];
    #1;
    acc = in_valid && in_ready18 && rst_n;
    if (rst_n && ov18 && out_ready) begin
      got_q.push_back(int'(y18));
      got_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic idle(output logic acc);
    step(0, 0, 0, 0, 0, 0, 1, acc);
  endtask

  int bp_exp[6] = '{-2, 0, 4, 10, 18, 28};
  int mode_exp[4] = '{21, 15, 35, 9};

  initial begin
    logic acc;
    int idx;
    logic signed [17:0] prev_y;

    // Reset
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1, acc);
    chk("rst_in_ready", 32'(in_ready18), 1);
    step(0, 0, 0, 0, 0, 0, 1, acc);
    chk("rst_out_valid", 32'(ov18), 0);
    chk("rst_y", y18, 0);
    rst_n = 1'b1;

    // Basic latency
    step(1, 10, 20, 7, 3, 0, 1, acc);
    chk("lat_accept", 32'(acc), 1);
    idle(acc); chk("lat_c1_valid", 32'(ov18), 0);
    idle(acc); chk("lat_c2_valid", 32'(ov18), 0);
    idle(acc); chk("lat_c3_valid", 32'(ov18), 1);
    chk("lat_y18", y18, 120);
    chk("lat_y16", y16, 120);
`ifdef ARITH_SAT_EN
    chk("lat_sat16", 32'(ysat16), 0);
`endif
    idle(acc); chk("lat_once", 32'(ov18), 0);

    // All four modes back to back
    got_q.delete(); got_cyc.delete();
    for (int m = 0; m < 4; m++) step(1, 5, 2, 4, 1, m, 1, acc);
    for (int k = 0; k < 6; k++) idle(acc);
    chk("mode_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk($sformatf("mode_y%0d", i), got_q[i], mode_exp[i]);
      chk($sformatf("mode_cyc%0d", i), got_cyc[i] - got_cyc[0], i);
    end

    // Positive overflow for OUT_W=16
    step(1, -128, -128, -128, 127, 0, 1, acc);
    idle(acc); idle(acc); idle(acc);
    chk("pos_valid", 32'(ov16), 1);
    chk("pos_y18", y18, 65280);
`ifdef ARITH_SAT_EN
    chk("pos_y16_sat", y16, 32767);
    chk("pos_sat16", 32'(ysat16), 1);
    chk("pos_sat18", 32'(ysat18), 0);
`else
    chk("pos_y16_wrap", y16, -256);
`endif

    // Negative overflow for OUT_W=16
    step(1, -128, -128, 127, -128, 0, 1, acc);
    idle(acc); idle(acc); idle(acc);
    chk("neg_y18", y18, -65280);
`ifdef ARITH_SAT_EN
    chk("neg_y16_sat", y16, -32768);
    chk("neg_sat16", 32'(ysat16), 1);
`else
    chk("neg_y16_wrap", y16, 256);
`endif

    // Backpressure: out_ready low for 4 cycles mid-stream; junk operands offered while stalled
    got_q.delete(); got_cyc.delete();
    idx = 0;
    prev_y = '0;
    for (int rel = 0; rel < 40 && got_q.size() < 6; rel++) begin
      logic ordy;
      ordy = !(rel >= 4 && rel <= 7);
      if (!ordy)
        step((idx < 6) ? 1 : 0, -7, -7, -7, -7, 3, 0, acc);
      else
        step((idx < 6) ? 1 : 0, idx + 1, 1, idx, 1, 0, 1, acc);
      if (acc) idx++;
      if (!ordy) begin
        chk("bp_in_ready", 32'(in_ready18), 0);
        chk("bp_valid_held", 32'(ov18), 1);
        if (rel > 4) chk("bp_y_held", y18, prev_y);
      end
      prev_y = y18;
    end
    chk("bp_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("bp_y%0d", i), got_q[i], bp_exp[i]);
    for (int k = 0; k < 4; k++) idle(acc);
    chk("bp_no_dup", got_q.size(), 6);

    // Reset with two operations in flight
    got_q.delete(); got_cyc.delete();
    step(1, 5, 2, 4, 1, 0, 1, acc);
    step(1, 5, 2, 4, 1, 1, 1, acc);
    rst_n = 1'b0;
    idle(acc);
    chk("mid_rst_in_ready", 32'(in_ready18), 1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle(acc);
      chk($sformatf("mid_rst_quiet%0d", k), 32'(ov18), 0);
    end
    step(1, 5, 2, 4, 1, 2, 1, acc);
    chk("post_rst_accept", 32'(acc), 1);
    idle(acc); chk("post_rst_c1", 32'(ov18), 0);
    idle(acc); chk("post_rst_c2", 32'(ov18), 0);
    idle(acc); chk("post_rst_c3", 32'(ov18), 1);
    chk("post_rst_y", y18, 35);
    idle(acc);
    chk("post_rst_count", got_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
